// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared adder into a single registered response slot.
// Latency 1 cycle; requests are granted only while the slot is empty or being drained this cycle.
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_carry,
  output logic [1:0]            rsp_id,
  input  logic                  rsp_ready
);

  localparam int IDW = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d;

  logic             accept_en;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             xfer;
  logic [WIDTH:0]   sum;

  // State register and response/pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  // Output decode from state
  always_comb begin
    rsp_valid = (state_q == FULL);
    accept_en = (state_q == EMPTY) || rsp_ready;
  end

  // First valid requester at or after ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    req_ready = '0;
    if (accept_en && !rst && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    sum = {1'b0, req_a[int'(gnt_idx)*WIDTH +: WIDTH]}
        + {1'b0, req_b[int'(gnt_idx)*WIDTH +: WIDTH]};
  end

  // Next state: a transfer always fills the slot, even while draining
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = FULL;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = sum[WIDTH-1:0];
      carry_d = sum[WIDTH];
      id_d    = gnt_idx;
      ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed scenarios plus randomized traffic.
module tb_adder_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_carry;
  logic [1:0]            rsp_id;
  logic                  rsp_ready;

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             c;
    int               id;
  } rsp_t;

  rsp_t q[$];
  int   glog[$];
  int   tests = 0;
  int   fails = 0;
  int   mptr  = 0;
  bit   armed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model + monitor: pending responses form a FIFO; grants follow the rotating priority.
  always @(negedge clk) begin
    if (rst) begin
      armed = 1;
      chk("req_ready_in_reset", 64'(req_ready), 64'd0);
      q.delete();
      mptr = 0;
    end else if (armed) begin
      bit   pend;
      bit   acc;
      int   g;
      logic [WIDTH:0] s;
      rsp_t r;
      pend = (q.size() > 0);
      chk("rsp_valid", 64'(rsp_valid), 64'(pend));
      if (pend && rsp_valid) begin
        chk("rsp_data", 64'(rsp_data), 64'(q[0].d));
        chk("rsp_carry", 64'(rsp_carry), 64'(q[0].c));
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      end
      acc = !pend || rsp_ready;
      if (pend && rsp_ready) void'(q.pop_front());
      g = -1;
      if (acc) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (mptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      chk("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      if (g >= 0) begin
        s = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]};
        r.d  = s[WIDTH-1:0];
        r.c  = s[WIDTH];
        r.id = g;
        q.push_back(r);
        glog.push_back(g);
        mptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic cyc(input logic [NREQ-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    if (sel == 2) return 32'h8000_0000;
    return $urandom;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[8];
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_carry", 64'(rsp_carry), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    @(posedge clk);
    #1;

    // Simple add from requester 0
    set_op(0, 32'd5, 32'd7);
    cyc(4'b0001, 1'b1);
    cyc(4'b0000, 1'b1);

    // Overflow from requester 2
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0002);
    cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b1);

    // Fairness under full load straight after reset
    do_reset();
    rand_ops();
    glog.delete();
    repeat (8) cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk("rr_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk("rr_order", 64'(glog[i]), 64'(exp_order[i]));

    // Backpressure with requesters 1 and 2 waiting
    do_reset();
    rand_ops();
    cyc(4'b0001, 1'b1);
    repeat (3) cyc(4'b0110, 1'b0);
    cyc(4'b0110, 1'b1);
    cyc(4'b0000, 1'b1);

    // Reset while a response is held
    cyc(4'b0001, 1'b1);
    rsp_ready = 1'b0;
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    glog.delete();
    cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("post_reset_first_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);

    // Drain without new request keeps the pointer (next after 2 is 3, then wraps to 0)
    cyc(4'b0100, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0011, 1'b1);
    cyc(4'b0000, 1'b1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        cyc(4'($urandom), 1'($urandom));
        rst = 1'b0;
      end else begin
        cyc(4'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters; the requester index is 2 bits wide.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  NREQ  per-requester valid for an add request.
REQ-006 req_a  input  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  NREQ*WIDTH  packed operand B, same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high on a clock edge.
REQ-009 rsp_valid  output  1  a registered result is present.
REQ-010 rsp_data  output  WIDTH  registered sum, req_a + req_b modulo 2^WIDTH.
REQ-011 rsp_carry  output  1  carry-out of the registered sum, bit WIDTH.
REQ-012 rsp_id  output  2  index of the requester that owns rsp_data.
REQ-013 rsp_ready  input  1  the consumer accepts the response when rsp_valid and rsp_ready are both high on a clock edge.

Function
REQ-014 The block SHALL contain one shared WIDTH-bit adder, one output register stage (rsp_*), and a 2-bit round-robin pointer ptr.
REQ-015 State machine, two states:
- EMPTY (rsp_valid=0).
- FULL (rsp_valid=1).
REQ-016 accept_en SHALL equal (state==EMPTY) or (rsp_ready==1).
REQ-017 With accept_en=0, req_ready SHALL be all zero; this holds even when req_valid is nonzero.
REQ-018 With accept_en=1, req_ready SHALL assert for exactly one requester, or for none if req_valid==0.
REQ-019 The granted requester SHALL be the first with req_valid set, searching ptr, ptr+1, ..., ptr+NREQ-1 with modulo-NREQ wrap.
REQ-020 req_ready SHALL be combinational from req_valid, ptr, state and rsp_ready.
REQ-021 On a transfer by requester g, the following SHALL be captured at that edge:
- rsp_data <= req_a[g] + req_b[g] (low WIDTH bits).
- rsp_carry <= bit WIDTH of the sum.
- rsp_id <= g.
- state <= FULL.
REQ-022 Latency SHALL be 1 cycle: the result is visible in the cycle after the transfer edge.
REQ-023 On a transfer, ptr SHALL update to (g+1) mod NREQ; ptr SHALL hold on cycles with no transfer.
REQ-024 In FULL with rsp_ready=0, the following SHALL hold stable until the response is accepted:
- rsp_data, rsp_carry and rsp_id.
- ptr.
REQ-025 In FULL, if rsp_ready=1 and no request is valid, state SHALL return to EMPTY.
REQ-026 In FULL, if rsp_ready=1 and a request is granted, the new result SHALL load in the same edge, state SHALL remain FULL, and there SHALL be no bubble (back-to-back throughput of 1 per cycle).
REQ-027 Operand overflow SHALL wrap modulo 2^WIDTH with rsp_carry=1, and no other flag SHALL be raised.
REQ-028 An unselected requester SHALL keep its req_valid without penalty; no request is dropped or reordered within a requester.
REQ-029 Fairness: under continuous requests from all NREQ requesters, each requester SHALL be granted exactly once in every NREQ consecutive transfers.

Reset
REQ-030 While rst=1 at a clock edge, the following SHALL hold:
- state <= EMPTY and rsp_valid <= 0.
- rsp_data <= 0, rsp_carry <= 0, rsp_id <= 0.
- ptr <= 0, so requester 0 has highest priority.
REQ-031 req_ready SHALL be all zero while rst=1.
REQ-032 Reset asserted mid-operation SHALL discard any pending response without presenting it.

Verification
REQ-033 Reset, then req_valid=0001, a=5, b=7, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_data=12, rsp_carry=0, rsp_id=0.
REQ-034 Single request from requester 2 with a=FFFFFFFF, b=00000002 -> rsp_data=00000001, rsp_carry=1, rsp_id=2.
REQ-035 All req_valid=1111 held for 8 cycles with rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3 and rsp_valid continuously high from cycle 2.
REQ-036 Backpressure: a response is pending with rsp_ready=0 for 3 cycles while req_valid=0110 -> req_ready=0000, rsp_* stable; when rsp_ready=1, requester 1 is granted on the same edge.
REQ-037 Reset mid-operation: rst=1 while FULL with rsp_ready=0 -> next cycle rsp_valid=0, ptr=0; after release, req_valid=1111 grants requester 0 first.
REQ-038 Drain without a new request: FULL, rsp_ready=1, req_valid=0 -> next cycle rsp_valid=0 and ptr unchanged.
